addsub16_seq: RTL

ADDSUB16_SEQ -- requirements
Module: addsub16_seq

---
 rtl/addsub16_seq_pkg.sv | 42 ++++
 rtl/addsub16_seq_add8_carry.sv | 22 ++
 rtl/addsub16_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/addsub16_seq_pkg.sv
// Shared CPU package: ALU16 op codes, sequencer states, flag bit positions
// and the per-byte operand selection used by the 16-bit add/sub sequencer.
package addsub16_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD16   = 3'd0,
        OP_ADD_SPE = 3'd1,
        OP_SUB16   = 3'd2,
        OP_INC16   = 3'd3,
        OP_DEC16   = 3'd4
    } alu16_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } addsub_state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // Second adder operand for one byte; subtraction feeds ~b with carry-in 1.
    function automatic logic [7:0] operand_b_byte(input alu16_op_t op,
                                                  input logic [15:0] b,
                                                  input logic high);
        logic [7:0] b_byte;
        logic [7:0] result;
        b_byte = high ? b[15:8] : b[7:0];
        case (op)
            OP_ADD16:   result = b_byte;
            OP_ADD_SPE: result = high ? {8{b[7]}} : b[7:0];
            OP_SUB16:   result = ~b_byte;
            OP_INC16:   result = high ? 8'h00 : 8'h01;
            OP_DEC16:   result = 8'hFF;
            default:    result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/addsub16_seq_add8_carry.sv
// 8-bit adder with carry-in, reporting carry out of bit 3 (half) and bit 7.
module add8_carry (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       h_out,
    output logic       c_out
);

    logic [8:0] full;
    logic [4:0] nibble;

    always_comb begin
        full   = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        nibble = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, cin};
        sum    = full[7:0];
        c_out  = full[8];
        h_out  = nibble[4];
    end

endmodule

// File: rtl/addsub16_seq.sv
// 16-bit add/sub sequencer: low byte in LOW, high byte in HIGH, through one
// shared 8-bit adder; result, flags and flag write enables land with done.
module addsub16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic [15:0] y,
    output logic [3:0]  f,
    output logic [3:0]  f_we,
    output logic        done
);

    import addsub16_seq_pkg::*;

    addsub_state_t state_q, state_d;
    alu16_op_t     op_q, op_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [7:0]    lo_sum_q, lo_sum_d;
    logic          lo_c_q, lo_c_d;
    logic          lo_h_q, lo_h_d;
    logic [15:0]   y_q, y_d;
    logic [3:0]    f_q, f_d;
    logic [3:0]    f_we_q, f_we_d;
    logic          done_q, done_d;

    logic [7:0]    add_a, add_b, add_sum;
    logic          add_cin, add_h, add_c;
    logic [15:0]   result;

    add8_carry u_add8 (
        .a     (add_a),
        .b     (add_b),
        .cin   (add_cin),
        .sum   (add_sum),
        .h_out (add_h),
        .c_out (add_c)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        lo_sum_d = lo_sum_q;
        lo_c_d   = lo_c_q;
        lo_h_d   = lo_h_q;
        y_d      = y_q;
        f_d      = f_q;
        f_we_d   = f_we_q;
        done_d   = 1'b0;
        add_a    = a_q[7:0];
        add_b    = operand_b_byte(op_q, b_q, 1'b0);
        add_cin  = (op_q == OP_SUB16);
        result   = {add_sum, lo_sum_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = alu16_op_t'(op);
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                lo_sum_d = add_sum;
                lo_c_d   = add_c;
                lo_h_d   = add_h;
                state_d  = ST_HIGH;
            end
            ST_HIGH: begin
                // The high byte's half carry is the carry out of bit 11.
                add_a   = a_q[15:8];
                add_b   = operand_b_byte(op_q, b_q, 1'b1);
                add_cin = lo_c_q;
                result  = {add_sum, lo_sum_q};
                y_d     = result;
                f_d     = 4'b0000;
                f_we_d  = 4'b0000;
                case (op_q)
                    OP_ADD16: begin
                        f_d[FLAG_H] = add_h;
                        f_d[FLAG_C] = add_c;
                        f_we_d      = 4'b0111;
                    end
                    OP_ADD_SPE: begin
                        f_d[FLAG_H] = lo_h_q;
                        f_d[FLAG_C] = lo_c_q;
                        f_we_d      = 4'b1111;
                    end
                    OP_SUB16: begin
                        f_d[FLAG_Z] = (result == 16'h0000);
                        f_d[FLAG_N] = 1'b1;
                        f_d[FLAG_H] = ~add_h;
                        f_d[FLAG_C] = ~add_c;
                        f_we_d      = 4'b1111;
                    end
                    default: begin
                        f_d    = 4'b0000;
                        f_we_d = 4'b0000;
                    end
                endcase
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD16;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            lo_sum_q <= 8'h00;
            lo_c_q   <= 1'b0;
            lo_h_q   <= 1'b0;
            y_q      <= 16'h0000;
            f_q      <= 4'b0000;
            f_we_q   <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_sum_q <= lo_sum_d;
            lo_c_q   <= lo_c_d;
            lo_h_q   <= lo_h_d;
            y_q      <= y_d;
            f_q      <= f_d;
            f_we_q   <= f_we_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign y    = y_q;
    assign f    = f_q;
    assign f_we = f_we_q;
    assign done = done_q;

endmodule
